// File: rtl/fifo_pkt_writer.sv
// ============================================================================
//  Module      : fifo_pkt_writer
//  Description : Write-side packet framer for the asynchronous FIFO. Accepts
//                a valid/ready beat stream, writes each beat as an untagged
//                FIFO word and closes every packet with one tagged trailer
//                word {1, trunc, seq[15:0], beats[13:0], xor-csum[31:0]}.
//                Packets longer than MAX_BEATS are truncated; the remaining
//                upstream beats are drained and dropped.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module fifo_pkt_writer #(
    parameter int FIFO_WIDTH = 64,
    parameter int MAX_BEATS  = 1024
) (
    input  logic                  wrclk,
    input  logic                  rrst_n,
    input  logic                  s_valid,
    output logic                  s_ready,
    input  logic [FIFO_WIDTH-2:0] s_data,
    input  logic                  s_last,
    input  logic                  fifo_full,
    output logic                  wr_en,
    output logic [FIFO_WIDTH-1:0] data_in,
    output logic [15:0]           pkt_seq,
    output logic                  trunc_pulse
);

    // Trailer field widths; the word layout assumes a 64-bit FIFO.
    localparam int CNT_W  = 14;
    localparam int CSUM_W = 32;
    localparam int SEQ_W  = 16;

    localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_BEATS);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_DATA    = 2'd1,
        ST_TRAILER = 2'd2,
        ST_DISCARD = 2'd3
    } state_t;

    state_t                  state;
    logic                    out_vld;
    logic [FIFO_WIDTH-1:0]   out_word;
    logic [CNT_W-1:0]        beat_cnt;
    logic [CSUM_W-1:0]       csum;
    logic                    trunc;

    logic                    slot_free;
    logic                    beat_acc;
    logic                    data_acc;
    logic [CNT_W-1:0]        cnt_next;
    logic                    at_limit;
    logic [FIFO_WIDTH-1:0]   trailer_word;

    // The output register is free when empty or draining into the FIFO this cycle.
    assign slot_free = ~out_vld | ~fifo_full;
    assign wr_en     = out_vld & ~fifo_full;
    assign data_in   = out_word;

    // Upstream handshake: stalled while the trailer is pending, always open while discarding.
    always_comb begin
        s_ready = 1'b0;
        case (state)
            ST_IDLE, ST_DATA: s_ready = slot_free;
            ST_TRAILER:       s_ready = 1'b0;
            ST_DISCARD:       s_ready = 1'b1;
            default:          s_ready = 1'b0;
        endcase
        // Keep the stream closed while the block is held in reset.
        if (!rrst_n) begin
            s_ready = 1'b0;
        end
    end

    assign beat_acc = s_valid & s_ready;
    assign data_acc = beat_acc & ((state == ST_IDLE) | (state == ST_DATA));
    assign cnt_next = beat_cnt + 1'b1;
    // Reaching the limit without s_last forces truncation (covers MAX_BEATS==1 from IDLE).
    assign at_limit = (cnt_next == MAX_CNT);

    assign trailer_word = {1'b1, trunc, pkt_seq[SEQ_W-1:0], beat_cnt, csum};

    // Framing FSM with the output word register, counters and checksum.
    always_ff @(posedge wrclk or negedge rrst_n) begin
        if (!rrst_n) begin
            state       <= ST_IDLE;
            out_vld     <= 1'b0;
            out_word    <= '0;
            beat_cnt    <= '0;
            csum        <= '0;
            pkt_seq     <= '0;
            trunc       <= 1'b0;
            trunc_pulse <= 1'b0;
        end else begin
            trunc_pulse <= 1'b0;

            // A word handed to the FIFO frees the slot unless reloaded below.
            if (wr_en) begin
                out_vld <= 1'b0;
            end

            case (state)
                ST_IDLE, ST_DATA: begin
                    if (data_acc) begin
                        out_word <= {1'b0, s_data};
                        out_vld  <= 1'b1;
                        beat_cnt <= cnt_next;
                        csum     <= csum ^ s_data[CSUM_W-1:0];
                        if (s_last) begin
                            trunc <= 1'b0;
                            state <= ST_TRAILER;
                        end else if (at_limit) begin
                            trunc <= 1'b1;
                            state <= ST_TRAILER;
                        end else begin
                            state <= ST_DATA;
                        end
                    end
                end

                ST_TRAILER: begin
                    if (slot_free) begin
                        out_word    <= trailer_word;
                        out_vld     <= 1'b1;
                        pkt_seq     <= pkt_seq + 1'b1;
                        beat_cnt    <= '0;
                        csum        <= '0;
                        trunc_pulse <= trunc;
                        state       <= trunc ? ST_DISCARD : ST_IDLE;
                    end
                end

                ST_DISCARD: begin
                    // Remaining beats of a truncated packet are consumed without writes.
                    if (beat_acc && s_last) begin
                        state <= ST_IDLE;
                    end
                end

                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_fifo_pkt_writer.sv
// ============================================================================
//  Module      : tb_fifo_pkt_writer
//  Description : Self-checking bench for fifo_pkt_writer. A packet-level
//                model predicts the exact FIFO word sequence; a monitor
//                compares every FIFO write against it.
//  Revision    : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_fifo_pkt_writer;

    localparam int MAXB = 4;

    logic        wrclk = 1'b0;
    logic        rrst_n = 1'b0;
    logic        s_valid = 1'b0;
    logic        s_last = 1'b0;
    logic        fifo_full = 1'b0;
    logic [62:0] s_data = '0;
    logic        s_ready;
    logic        wr_en;
    logic [63:0] data_in;
    logic [15:0] pkt_seq;
    logic        trunc_pulse;

    fifo_pkt_writer #(.FIFO_WIDTH(64), .MAX_BEATS(MAXB)) dut (
        .wrclk       (wrclk),
        .rrst_n      (rrst_n),
        .s_valid     (s_valid),
        .s_ready     (s_ready),
        .s_data      (s_data),
        .s_last      (s_last),
        .fifo_full   (fifo_full),
        .wr_en       (wr_en),
        .data_in     (data_in),
        .pkt_seq     (pkt_seq),
        .trunc_pulse (trunc_pulse)
    );

    always #5 wrclk = ~wrclk;

    int n_vec = 0;
    int n_err = 0;

    task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Packet-level reference model
    logic [63:0] exp_q[$];
    logic [15:0] seq_m = '0;
    int          trunc_exp = 0;
    int          trunc_seen = 0;
    logic [63:0] last_word = '0;
    logic [62:0] pkt_data [0:15];
    int          full_mode = 0;   // 0: never full, 1: random, 2: forced full

    task automatic model_pkt(input int n);
        int          kept;
        bit          tr;
        logic [31:0] cs;
        kept = (n < MAXB) ? n : MAXB;
        tr   = (n > MAXB);
        cs   = '0;
        for (int i = 0; i < kept; i++) begin
            exp_q.push_back({1'b0, pkt_data[i]});
            cs = cs ^ pkt_data[i][31:0];
        end
        exp_q.push_back({1'b1, tr, seq_m, 14'(kept), cs});
        seq_m = seq_m + 16'd1;
        if (tr) trunc_exp++;
    endtask

    task automatic fill_rand(input int n);
        for (int i = 0; i < n; i++) pkt_data[i] = 63'({$urandom, $urandom});
    endtask

    // Drive 'count' beats of an n-beat packet, holding each until accepted.
    task automatic send_beats(input int n, input int count);
        int t;
        for (int i = 0; i < count; i++) begin
            @(negedge wrclk);
            s_valid = 1'b1;
            s_data  = pkt_data[i];
            s_last  = (i == n - 1);
            #1;
            t = 0;
            while (!s_ready && t < 200) begin
                @(negedge wrclk);
                #1;
                t++;
            end
            if (t >= 200) check_val("beat_accept_timeout", 64'(t), 64'd0);
            @(posedge wrclk);
        end
        @(negedge wrclk);
        s_valid = 1'b0;
        s_last  = 1'b0;
    endtask

    task automatic run_pkt(input int n);
        model_pkt(n);
        send_beats(n, n);
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while (exp_q.size() > 0 && t < 500) begin
            @(negedge wrclk);
            t++;
        end
        check_val("drain_pending_words", 64'(exp_q.size()), 64'd0);
    endtask

    // FIFO full generator, updated away from the active edge
    initial forever begin
        @(negedge wrclk);
        fifo_full = (full_mode == 2) || (full_mode == 1 && $urandom_range(0, 99) < 30);
    end

    // Write monitor: every FIFO write must be the next predicted word
    initial forever begin
        @(negedge wrclk);
        #2;
        if (rrst_n) begin
            if (trunc_pulse) trunc_seen++;
            if (fifo_full) check_val("wr_en_while_full", 64'(wr_en), 64'd0);
            if (wr_en) begin
                check_val("write_expected", 64'(exp_q.size() > 0), 64'd1);
                if (exp_q.size() > 0) check_val("fifo_word", data_in, exp_q.pop_front());
                last_word = data_in;
            end
        end
    end

    // Upstream stability while a beat is stalled
    initial begin
        logic        p_hold;
        logic [62:0] p_data;
        logic        p_last;
        p_hold = 1'b0;
        p_data = '0;
        p_last = 1'b0;
        forever begin
            @(posedge wrclk);
            if (rrst_n && p_hold) begin
                check_val("hold_valid", 64'(s_valid), 64'd1);
                check_val("hold_data", 64'(s_data), 64'(p_data));
                check_val("hold_last", 64'(s_last), 64'(p_last));
            end
            p_hold = rrst_n & s_valid & ~s_ready;
            p_data = s_data;
            p_last = s_last;
        end
    end

    initial begin
        logic [63:0] prev_out;
        int          n;

        // Reset state
        repeat (3) @(negedge wrclk);
        #1;
        check_val("rst_wr_en", 64'(wr_en), 64'd0);
        check_val("rst_s_ready", 64'(s_ready), 64'd0);
        check_val("rst_data_in", data_in, 64'd0);
        check_val("rst_pkt_seq", 64'(pkt_seq), 64'd0);
        check_val("rst_trunc_pulse", 64'(trunc_pulse), 64'd0);
        @(negedge wrclk);
        rrst_n = 1'b1;

        // Two identical 3-beat packets; upper payload bits must not affect csum
        for (int k = 0; k < 2; k++) begin
            fill_rand(3);
            pkt_data[0][31:0] = 32'h1111_1111;
            pkt_data[1][31:0] = 32'h2222_2222;
            pkt_data[2][31:0] = 32'h4444_4444;
            run_pkt(3);
            wait_drain();
            check_val(k == 0 ? "trailer_3beat_seq0" : "trailer_3beat_seq1", last_word,
                      k == 0 ? 64'h8000_0003_7777_7777 : 64'h8000_4003_7777_7777);
        end

        // Single-beat packet
        pkt_data[0] = {31'h1234_5678, 32'hA5A5_A5A5};
        run_pkt(1);
        wait_drain();
        check_val("trailer_1beat_seq2", last_word, 64'h8000_8001_A5A5_A5A5);
        check_val("pkt_seq_after_3", 64'(pkt_seq), 64'd3);

        // FIFO full held for 5 cycles mid-packet
        fill_rand(4);
        model_pkt(4);
        prev_out = '0;
        fork
            send_beats(4, 4);
            begin
                @(negedge wrclk);
                #4 full_mode = 2;
                for (int k = 0; k < 5; k++) begin
                    @(negedge wrclk);
                    #3;
                    if (k >= 2) begin
                        check_val("full_s_ready", 64'(s_ready), 64'd0);
                        check_val("full_data_stable", data_in, prev_out);
                    end
                    prev_out = data_in;
                end
                full_mode = 0;
            end
        join
        wait_drain();

        // Truncation: 6 beats with MAX_BEATS=4
        fill_rand(6);
        run_pkt(6);
        wait_drain();
        check_val("trunc_flag", 64'(last_word[62]), 64'd1);
        check_val("trunc_count", 64'(last_word[45:32]), 64'd4);
        check_val("trunc_pulses", 64'(trunc_seen), 64'(trunc_exp));

        // Randomized traffic with random backpressure
        full_mode = 1;
        repeat (150) begin
            n = $urandom_range(1, 7);
            fill_rand(n);
            run_pkt(n);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 3)) @(negedge wrclk);
        end
        #4 full_mode = 0;
        wait_drain();
        check_val("rand_pkt_seq", 64'(pkt_seq), 64'(seq_m));
        check_val("rand_trunc_pulses", 64'(trunc_seen), 64'(trunc_exp));

        // Reset after beat 2 of a 5-beat packet
        fill_rand(5);
        exp_q.push_back({1'b0, pkt_data[0]});
        exp_q.push_back({1'b0, pkt_data[1]});
        send_beats(5, 2);
        wait_drain();
        @(negedge wrclk);
        #1 rrst_n = 1'b0;
        #1;
        check_val("midrst_wr_en", 64'(wr_en), 64'd0);
        check_val("midrst_s_ready", 64'(s_ready), 64'd0);
        check_val("midrst_data_in", data_in, 64'd0);
        check_val("midrst_pkt_seq", 64'(pkt_seq), 64'd0);
        check_val("midrst_trunc_pulse", 64'(trunc_pulse), 64'd0);
        seq_m = '0;
        exp_q.delete();
        @(negedge wrclk);
        rrst_n = 1'b1;
        fill_rand(2);
        run_pkt(2);
        wait_drain();
        check_val("postrst_seq", 64'(last_word[61:46]), 64'd0);
        check_val("postrst_count", 64'(last_word[45:32]), 64'd2);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

`default_nettype wire
